// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// Optional 8E1 framing is enabled by defining UART_PARITY_EN.
package uart_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int          DEF_CLKS_PER_BIT = 347;
    localparam logic [31:0] DEF_END_WORD     = 32'h0000_0FFF;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, bit-timing FSM, byte/error pulses.
// With UART_PARITY_EN defined, an even-parity bit follows the data bits.
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // armed: a start is only honoured once the line has been seen idle-high
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q | rx_sync;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (armed_q && !rx_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_sync;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_sync) begin
`ifdef UART_PARITY_EN
                        perr_d = par_bad_q;
                        vld_d  = !par_bad_q;
`else
                        vld_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_o      = shift_q;
    assign byte_vld_o  = vld_q;
    assign frame_err_o = ferr_q;
`ifdef UART_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a UART-streamed program into instruction memory, then releases the core.
// Define UART_PARITY_EN for 8E1 framing and the parity_err_o flag.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] END_WORD     = DEF_END_WORD
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              prog_done_o,
    output logic              core_hold_o,
    output logic              frame_err_o,
    output logic              overflow_o
`ifdef UART_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [1:0]        LAST_IDX  = 2'(BYTES_PER_WORD - 1);

    logic [7:0]        rx_byte;
    logic              byte_vld;
    logic              ferr_pulse;
    logic [1:0]        byte_idx;
    logic [31:0]       word_q;
    logic              word_vld;
    logic [ADDR_W-1:0] addr_cnt;
    logic              full_q;
`ifdef UART_PARITY_EN
    logic              perr_pulse;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_vld_o   (byte_vld),
        .frame_err_o  (ferr_pulse)
`ifdef UART_PARITY_EN
        ,
        .parity_err_o (perr_pulse)
`endif
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            byte_idx <= '0;
            word_q   <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= byte_vld && (byte_idx == LAST_IDX);
            if (byte_vld) begin
                word_q[{byte_idx, 3'b000} +: 8] <= rx_byte;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    // full_q distinguishes "memory full" completion from the terminator
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            addr_cnt    <= '0;
            prog_done_o <= 1'b0;
            full_q      <= 1'b0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            if (ferr_pulse) begin
                frame_err_o <= 1'b1;
            end
            if (word_vld) begin
                if (!prog_done_o) begin
                    if (word_q == END_WORD) begin
                        prog_done_o <= 1'b1;
                    end else begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_cnt;
                        mem_wdata_o <= word_q;
                        if (addr_cnt == LAST_ADDR) begin
                            prog_done_o <= 1'b1;
                            full_q      <= 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end else if (full_q) begin
                    overflow_o <= 1'b1;
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            parity_err_o <= 1'b0;
        end else if (perr_pulse) begin
            parity_err_o <= 1'b1;
        end
    end
`endif

    assign core_hold_o = ~prog_done_o;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a write scoreboard.
// Parity framing is driven when UART_PARITY_EN is defined.
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          done;
    logic          hold;
    logic          ferr;
    logic          ovf;
`ifdef UART_PARITY_EN
    logic          perr;
`endif

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  obs_rd = 0;
    int  errors = 0;
    int  checks = 0;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .END_WORD     (32'h0000_0FFF)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_i         (rx),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .prog_done_o  (done),
        .core_hold_o  (hold),
        .frame_err_o  (ferr),
        .overflow_o   (ovf)
`ifdef UART_PARITY_EN
        ,
        .parity_err_o (perr)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            obs_q.push_back(wr_t'({mem_addr, mem_wdata}));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_time(b[i]);
        end
`ifdef UART_PARITY_EN
        bit_time(^b);
`endif
        bit_time(stop_bit);
        bit_time(1'b1);
        bit_time(1'b1);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        wr_t e;
        wr_t o;
        check({tag, "_nwr"}, obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                o = obs_q[obs_rd];
                obs_rd++;
                check({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
                check({tag, "_data"}, o.data, e.data);
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(hold), 32'd1);
        check({tag, "_ferr"}, 32'(ferr), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        obs_rd = obs_q.size();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: single word, reset state
        do_reset();
        check_reset_outs("rst");
        expect_wr(3'd0, 32'h1234_5678);
        send_word(32'h1234_5678);
        drain("w1");
        check("w1_done", 32'(done), 32'd0);
        check("w1_hold", 32'(hold), 32'd1);

        // 2: two words then terminator, one more word ignored
        do_reset();
        expect_wr(3'd0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        expect_wr(3'd1, 32'h0000_0013);
        send_word(32'h0000_0013);
        send_word(32'h0000_0FFF);
        drain("term");
        check("term_done", 32'(done), 32'd1);
        check("term_hold", 32'(hold), 32'd0);
        send_word(32'h1111_1111);
        drain("post");
        check("post_ovf", 32'(ovf), 32'd0);

        // 3: stop-bit error then a good word
        do_reset();
        send_byte(8'h55, 1'b0);
        check("ferr_set", 32'(ferr), 32'd1);
        expect_wr(3'd0, 32'hDDCC_BBAA);
        send_word(32'hDDCC_BBAA);
        drain("ferr");
        check("ferr_sticky", 32'(ferr), 32'd1);

        // 4: fill memory, then overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            expect_wr(3'(i), 32'hA500_0000 + 32'(i));
            send_word(32'hA500_0000 + 32'(i));
        end
        drain("fill");
        check("fill_done", 32'(done), 32'd1);
        check("fill_ovf0", 32'(ovf), 32'd0);
        send_word(32'h5A5A_5A5A);
        drain("ovfw");
        check("ovf_set", 32'(ovf), 32'd1);

        // 5: short low glitch while idle
        do_reset();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        drain("glitch");
        check("glitch_ferr", 32'(ferr), 32'd0);
        expect_wr(3'd0, 32'h0BAD_F00D);
        send_word(32'h0BAD_F00D);
        drain("glitch_w");

        // 6: async reset mid-word
        do_reset();
        expect_wr(3'd0, 32'h1122_3344);
        send_word(32'h1122_3344);
        drain("pre");
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outs("arst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        expect_wr(3'd0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        drain("arst_w");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Receive-side counterpart of the bench UART program transmitter.
- Sits in the user project area.
- Deserialises 8N1 UART bytes from mprj_io[5], packs them little-endian into 32-bit instruction words and writes them sequentially into instruction memory.
- On the end-of-program word, raises a sticky ready flag that drives mprj_io[37] and releases the core from hold.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200).
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words.
- END_WORD, 32'h0000_0FFF, terminator word; it is never written to memory.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial input, idle high, asynchronous to wb_clk_i.
- mem_we_o  out  1  single-cycle write strobe.
- mem_addr_o  out  ADDR_W  word address of the current write.
- mem_wdata_o  out  32  word being written.
- prog_done_o  out  1  sticky; END_WORD received, or memory full.
- core_hold_o  out  1  high while loading; equals ~prog_done_o.
- frame_err_o  out  1  sticky; a stop bit was sampled low.
- overflow_o  out  1  sticky; a word arrived after the last address was written.

Behaviour:
- Reset: one clock; wb_rst_i is asynchronous and active-high.
  - All flops clear: FSM to IDLE, counters 0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, prog_done_o=0, frame_err_o=0, overflow_o=0, core_hold_o=1.
  - Reset mid-byte or mid-word discards the partial data.
- rx_i passes through a 2-flop synchroniser, reset value 1. Only the synchronised value is used. Latency is 2 cycles.
- Receiver FSM:
  - IDLE: wait for synchronised rx=0, then go to START with bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE; no error is flagged.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: sample after CLKS_PER_BIT cycles.
    - 1: byte valid, pulse internal byte_vld for one cycle, go to IDLE.
    - 0: discard the byte, set frame_err_o, go to IDLE. IDLE accepts a new start only once rx has first been seen high.
- Word packer:
  - 2-bit byte index. Byte k goes to word bits [8k+7:8k].
  - On the 4th valid byte the word is complete in the following cycle.
- Word handling:
  - Word == END_WORD: set prog_done_o; no write.
  - Otherwise: mem_we_o=1 for exactly one cycle, mem_addr_o = current address, mem_wdata_o = word. Address increments after the strobe.
  - Write at address 2**ADDR_W-1: after the write, set prog_done_o (memory full).
- After prog_done_o is set:
  - Further bytes are still received but never written.
  - Any completed word sets overflow_o if prog_done_o was caused by full memory; otherwise it is ignored.
- A frame error does not advance the byte index; the packer stays aligned to the next valid byte.
- mem_addr_o and mem_wdata_o hold their last values between strobes.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: frame is 8E1. A PARITY state follows DATA and samples one bit. If the data bits XOR the parity bit ≠ 0, the byte is discarded and the sticky port parity_err_o (out, 1, reset 0) is set.
- Not defined: frame is 8N1, with no PARITY state and no parity_err_o port.

Decomposition:
- Shared package uart_prog_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Default CLKS_PER_BIT and END_WORD constants.
  - Frame-length localparams.
- One sub-module, uart_rx_byte: synchroniser, bit FSM and byte_vld/frame_err outputs.
- The top-level uart_prog_loader holds the packer, address counter and flags.

Test Plan:
- All tests use CLKS_PER_BIT=8 and ADDR_W=3.
- Bytes 78 56 34 12 -> one mem_we_o pulse, addr 0, wdata 32'h1234_5678; prog_done_o=0, core_hold_o=1.
- Words 0xDEADBEEF, 0x00000013, then FF 0F 00 00 -> writes at addr 0 and 1 only; prog_done_o=1 and core_hold_o=0 after the terminator; no third strobe.
- Byte with stop bit forced 0, then 4 good bytes AA BB CC DD -> frame_err_o=1; one write, wdata 32'hDDCC_BBAA.
- 8 non-terminator words, then a 9th -> writes at addr 0..7; prog_done_o=1 after addr 7; 9th word gives no strobe and sets overflow_o=1.
- 3-cycle low glitch on rx_i while idle -> no byte, no flags; the next valid word writes at addr 0.
- wb_rst_i asserted asynchronously after 2 bytes of a word -> all outputs at reset values immediately; a following full word writes at addr 0 with only the new bytes.
